// File: rtl/ofdm_pkg.sv
// Shared OFDM constants and types for the receive-side Hermitian extractor.
package ofdm_pkg;

    localparam int NFFT     = 64;
    localparam int NSC      = NFFT / 2;
    localparam int ADDR_W   = 6;
    localparam int SC_W     = 5;
    localparam int SAMPLE_W = 16;

    // Buffer address: ping-pong bank select plus FFT bin.
    typedef struct packed {
        logic              bank;
        logic [ADDR_W-1:0] idx;
    } ram_addr_t;

    // Mirror bin of k: (NFFT - k) mod NFFT, so bin 0 mirrors onto itself.
    function automatic logic [ADDR_W-1:0] mirror_idx(input logic [SC_W-1:0] k);
        return ADDR_W'(NFFT - int'(k));
    endfunction

endpackage

// File: rtl/hermitian_bank_ram.sv
// Two-bank symbol buffer: one write port, two synchronous read ports (bin and its mirror).
module hermitian_bank_ram
    import ofdm_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W
) (
    input  logic               clk,
    input  logic               we,
    input  ram_addr_t          waddr,
    input  logic [2*WIDTH-1:0] wdata,
    input  ram_addr_t          raddr_a,
    input  ram_addr_t          raddr_b,
    output logic [2*WIDTH-1:0] rdata_a,
    output logic [2*WIDTH-1:0] rdata_b
);

    logic [2*WIDTH-1:0] mem [0:2*NFFT-1];

    // Single write port shared by both banks; contents are never cleared.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Both read ports registered: one cycle from address to data.
    always_ff @(posedge clk) begin
        rdata_a <= mem[raddr_a];
        rdata_b <= mem[raddr_b];
    end

endmodule

// File: rtl/hermitian_extract.sv
// Recovers 32 data subcarriers from a 64-point FFT symbol: Y[k] = (X[k] + conj(X[64-k])) / 2.
module hermitian_extract
    import ofdm_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W
) (
    input  logic              deh_clk,
    input  logic              deh_rst,
    input  logic              din_valid,
    input  logic [ADDR_W-1:0] din_index,
    input  logic [WIDTH-1:0]  deh_real_din,
    input  logic [WIDTH-1:0]  deh_imag_din,
    output logic              dout_valid,
    output logic [SC_W-1:0]   dout_index,
    output logic [WIDTH-1:0]  deh_real_dout,
    output logic [WIDTH-1:0]  deh_imag_dout,
    output logic              overrun
);

    logic              wbank;
    logic              rbank;
    logic              rd_active;
    logic [SC_W-1:0]   rd_k;
    logic [SC_W-1:0]   k_d1;
    logic [1:0]        vld_pipe;   // [0]: buffer data valid, [1]: output valid

    logic              sym_end;
    logic              busy;
    ram_addr_t         waddr;
    ram_addr_t         raddr_a;
    ram_addr_t         raddr_b;
    logic [2*WIDTH-1:0] rdata_a;
    logic [2*WIDTH-1:0] rdata_b;

    logic signed [WIDTH-1:0] a_re, a_im, b_re, b_im;
    logic signed [WIDTH:0]   re_sum, im_sum;

    // Only bin 63 closes a symbol; the engine is still busy until its last bin (k=31) is issued.
    assign sym_end = din_valid && (din_index == ADDR_W'(NFFT - 1));
    assign busy    = rd_active && (rd_k != SC_W'(NSC - 1));

    assign waddr   = '{bank: wbank, idx: din_index};
    assign raddr_a = '{bank: rbank, idx: {1'b0, rd_k}};
    assign raddr_b = '{bank: rbank, idx: mirror_idx(rd_k)};

    hermitian_bank_ram #(.WIDTH(WIDTH)) u_ram (
        .clk     (deh_clk),
        .we      (din_valid),
        .waddr   (waddr),
        .wdata   ({deh_real_din, deh_imag_din}),
        .raddr_a (raddr_a),
        .raddr_b (raddr_b),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b)
    );

    // One extra bit of headroom keeps the sum exact; halving then always fits in WIDTH.
    assign a_re   = rdata_a[2*WIDTH-1:WIDTH];
    assign a_im   = rdata_a[WIDTH-1:0];
    assign b_re   = rdata_b[2*WIDTH-1:WIDTH];
    assign b_im   = rdata_b[WIDTH-1:0];
    assign re_sum = (WIDTH+1)'(a_re) + (WIDTH+1)'(b_re);
    assign im_sum = (WIDTH+1)'(a_im) - (WIDTH+1)'(b_im);

    // Bank control and read counter; a symbol ending while busy is dropped but still flips wbank.
    always_ff @(posedge deh_clk) begin
        if (deh_rst) begin
            wbank     <= 1'b0;
            rbank     <= 1'b0;
            rd_active <= 1'b0;
            rd_k      <= '0;
            overrun   <= 1'b0;
        end else begin
            overrun <= sym_end && busy;
            if (sym_end) wbank <= ~wbank;
            if (sym_end && !busy) begin
                rd_active <= 1'b1;
                rd_k      <= '0;
                rbank     <= wbank;
            end else if (rd_active) begin
                if (rd_k == SC_W'(NSC - 1)) rd_active <= 1'b0;
                rd_k <= rd_k + 1'b1;
            end
        end
    end

    // Valid/index pipeline alongside buffer latency; outputs forced to zero outside bursts.
    always_ff @(posedge deh_clk) begin
        if (deh_rst) begin
            vld_pipe      <= '0;
            k_d1          <= '0;
            dout_index    <= '0;
            deh_real_dout <= '0;
            deh_imag_dout <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], rd_active};
            k_d1     <= rd_k;
            if (vld_pipe[0]) begin
                dout_index    <= k_d1;
                deh_real_dout <= WIDTH'(re_sum >>> 1);
                deh_imag_dout <= WIDTH'(im_sum >>> 1);
            end else begin
                dout_index    <= '0;
                deh_real_dout <= '0;
                deh_imag_dout <= '0;
            end
        end
    end

    assign dout_valid = vld_pipe[1];

endmodule
